// File: rtl/sonar_serial_pkg.sv
// Shared constants, state encodings and helpers for the sonar serial receiver.
// Receiver frame: start, 7 data bits LSB first, odd parity, 2 stop bits.
package sonar_serial_pkg;

    localparam int unsigned DIVISOR_PADRAO = 434;

    localparam logic [6:0] ASCII_ZERO    = 7'h30;
    localparam logic [6:0] ASCII_NOVE    = 7'h39;
    localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
    localparam logic [6:0] ASCII_HASH    = 7'h23;

    typedef enum logic [3:0] {
        RX_INICIAL         = 4'h0,
        RX_ESPERA_INICIO   = 4'h1,
        RX_CONFIRMA_INICIO = 4'h2,
        RX_DADOS           = 4'h3,
        RX_PARIDADE        = 4'h4,
        RX_PARADA1         = 4'h5,
        RX_PARADA2         = 4'h6
    } estado_rx_t;

    typedef enum logic [3:0] {
        P_ESPERA  = 4'h0,
        P_ANG1    = 4'h1,
        P_ANG2    = 4'h2,
        P_VIRGULA = 4'h3,
        P_DIST0   = 4'h4,
        P_DIST1   = 4'h5,
        P_DIST2   = 4'h6,
        P_DIST3   = 4'h7,
        P_FIM     = 4'h8
    } estado_parser_t;

    function automatic logic eh_digito(input logic [6:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
    endfunction

endpackage

// File: rtl/rx_serial_7o2.sv
// UART receiver for 7 data bits, odd parity, 2 stop bits.
// Emits a one-cycle byte_valido with the byte and its parity/stop status.
module rx_serial_7o2
    import sonar_serial_pkg::*;
#(
    parameter int unsigned DIVISOR     = DIVISOR_PADRAO,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic       byte_valido,
    output logic [6:0] dado,
    output logic       par_ok,
    output logic       stop_ok,
    output logic [3:0] db_estado_rx
);

    localparam int unsigned CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] FIM_BIT  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] MEIO_BIT = CW'(DIVISOR / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx;
    logic                   rx_ant_q, rx_ant_d;
    estado_rx_t             estado_q, estado_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             nbit_q, nbit_d;
    logic [6:0]             shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop1_q, stop1_d;
    logic                   byte_valido_q, byte_valido_d;
    logic [6:0]             dado_q, dado_d;
    logic                   par_ok_q, par_ok_d;
    logic                   stop_ok_q, stop_ok_d;

    assign rx = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], entrada_serial};
        rx_ant_d      = rx;
        estado_d      = estado_q;
        cnt_d         = cnt_q + 1'b1;
        nbit_d        = nbit_q;
        shift_d       = shift_q;
        par_bit_d     = par_bit_q;
        stop1_d       = stop1_q;
        byte_valido_d = 1'b0;
        dado_d        = dado_q;
        par_ok_d      = par_ok_q;
        stop_ok_d     = stop_ok_q;

        case (estado_q)
            RX_INICIAL: estado_d = RX_ESPERA_INICIO;
            RX_ESPERA_INICIO: begin
                if (rx_ant_q && !rx) begin
                    estado_d = RX_CONFIRMA_INICIO;
                    cnt_d    = '0;
                end
            end
            // A start bit that is high again at mid-bit is a glitch.
            RX_CONFIRMA_INICIO: begin
                if (cnt_q == MEIO_BIT) begin
                    cnt_d    = '0;
                    nbit_d   = '0;
                    estado_d = rx ? RX_ESPERA_INICIO : RX_DADOS;
                end
            end
            RX_DADOS: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[6:1]};
                    nbit_d  = nbit_q + 3'd1;
                    if (nbit_q == 3'd6) estado_d = RX_PARIDADE;
                end
            end
            RX_PARIDADE: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d     = '0;
                    par_bit_d = rx;
                    estado_d  = RX_PARADA1;
                end
            end
            RX_PARADA1: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d    = '0;
                    stop1_d  = rx;
                    estado_d = RX_PARADA2;
                end
            end
            RX_PARADA2: begin
                if (cnt_q == FIM_BIT) begin
                    cnt_d         = '0;
                    byte_valido_d = 1'b1;
                    dado_d        = shift_q;
                    par_ok_d      = ^{shift_q, par_bit_q};
                    stop_ok_d     = stop1_q;
                    estado_d      = RX_ESPERA_INICIO;
                end
            end
            default: estado_d = RX_INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q        <= '1;
            rx_ant_q      <= 1'b1;
            estado_q      <= RX_INICIAL;
            cnt_q         <= '0;
            nbit_q        <= '0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            stop1_q       <= 1'b0;
            byte_valido_q <= 1'b0;
            dado_q        <= '0;
            par_ok_q      <= 1'b0;
            stop_ok_q     <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            rx_ant_q      <= rx_ant_d;
            estado_q      <= estado_d;
            cnt_q         <= cnt_d;
            nbit_q        <= nbit_d;
            shift_q       <= shift_d;
            par_bit_q     <= par_bit_d;
            stop1_q       <= stop1_d;
            byte_valido_q <= byte_valido_d;
            dado_q        <= dado_d;
            par_ok_q      <= par_ok_d;
            stop_ok_q     <= stop_ok_d;
        end
    end

    assign byte_valido  = byte_valido_q;
    assign dado         = dado_q;
    assign par_ok       = par_ok_q;
    assign stop_ok      = stop_ok_q;
    assign db_estado_rx = estado_q;

endmodule

// File: rtl/sonar_receptor_serial.sv
// Sonar link receiver: parses "aaa,dddd#" frames into BCD angle/distance
// and commits them atomically with a one-cycle pronto strobe.
module sonar_receptor_serial
    import sonar_serial_pkg::*;
#(
    parameter int unsigned DIVISOR     = DIVISOR_PADRAO,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [15:0] distancia,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic [3:0]  db_estado,
    output logic [3:0]  db_estado_rx,
    output logic [6:0]  db_dado
);

    logic       byte_valido;
    logic [6:0] dado;
    logic       par_ok;
    logic       stop_ok;
    logic       digito;

    rx_serial_7o2 #(
        .DIVISOR     (DIVISOR),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .byte_valido    (byte_valido),
        .dado           (dado),
        .par_ok         (par_ok),
        .stop_ok        (stop_ok),
        .db_estado_rx   (db_estado_rx)
    );

    estado_parser_t estado_q, estado_d;
    logic [11:0]    ang_sh_q, ang_sh_d;
    logic [15:0]    dist_sh_q, dist_sh_d;
    logic [11:0]    angulo_q, angulo_d;
    logic [15:0]    distancia_q, distancia_d;
    logic           pronto_q, pronto_d;
    logic           erro_paridade_q, erro_paridade_d;
    logic           erro_quadro_q, erro_quadro_d;
    logic           rejeita;

    assign digito = eh_digito(dado);

    always_comb begin
        estado_d        = estado_q;
        ang_sh_d        = ang_sh_q;
        dist_sh_d       = dist_sh_q;
        angulo_d        = angulo_q;
        distancia_d     = distancia_q;
        pronto_d        = 1'b0;
        erro_paridade_d = 1'b0;
        erro_quadro_d   = 1'b0;
        rejeita         = 1'b0;

        if (byte_valido) begin
            // Line-level errors discard the frame even in ESPERA.
            if (!par_ok || !stop_ok) begin
                erro_paridade_d = !par_ok;
                erro_quadro_d   = !stop_ok;
                estado_d        = P_ESPERA;
            end else begin
                case (estado_q)
                    P_ESPERA: begin
                        if (digito) begin
                            ang_sh_d[11:8] = dado[3:0];
                            estado_d       = P_ANG1;
                        end
                    end
                    P_ANG1: begin
                        if (digito) begin
                            ang_sh_d[7:4] = dado[3:0];
                            estado_d      = P_ANG2;
                        end else rejeita = 1'b1;
                    end
                    P_ANG2: begin
                        if (digito) begin
                            ang_sh_d[3:0] = dado[3:0];
                            estado_d      = P_VIRGULA;
                        end else rejeita = 1'b1;
                    end
                    P_VIRGULA: begin
                        if (dado == ASCII_VIRGULA) estado_d = P_DIST0;
                        else rejeita = 1'b1;
                    end
                    P_DIST0: begin
                        if (digito) begin
                            dist_sh_d[15:12] = dado[3:0];
                            estado_d         = P_DIST1;
                        end else rejeita = 1'b1;
                    end
                    P_DIST1: begin
                        if (digito) begin
                            dist_sh_d[11:8] = dado[3:0];
                            estado_d        = P_DIST2;
                        end else rejeita = 1'b1;
                    end
                    P_DIST2: begin
                        if (digito) begin
                            dist_sh_d[7:4] = dado[3:0];
                            estado_d       = P_DIST3;
                        end else rejeita = 1'b1;
                    end
                    P_DIST3: begin
                        if (digito) begin
                            dist_sh_d[3:0] = dado[3:0];
                            estado_d       = P_FIM;
                        end else rejeita = 1'b1;
                    end
                    P_FIM: begin
                        if (dado == ASCII_HASH) begin
                            angulo_d    = ang_sh_q;
                            distancia_d = dist_sh_q;
                            pronto_d    = 1'b1;
                            estado_d    = P_ESPERA;
                        end else rejeita = 1'b1;
                    end
                    default: estado_d = P_ESPERA;
                endcase
                if (rejeita) begin
                    erro_quadro_d = 1'b1;
                    estado_d      = P_ESPERA;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q        <= P_ESPERA;
            ang_sh_q        <= '0;
            dist_sh_q       <= '0;
            angulo_q        <= '0;
            distancia_q     <= '0;
            pronto_q        <= 1'b0;
            erro_paridade_q <= 1'b0;
            erro_quadro_q   <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            ang_sh_q        <= ang_sh_d;
            dist_sh_q       <= dist_sh_d;
            angulo_q        <= angulo_d;
            distancia_q     <= distancia_d;
            pronto_q        <= pronto_d;
            erro_paridade_q <= erro_paridade_d;
            erro_quadro_q   <= erro_quadro_d;
        end
    end

    assign angulo        = angulo_q;
    assign distancia     = distancia_q;
    assign pronto        = pronto_q;
    assign erro_paridade = erro_paridade_q;
    assign erro_quadro   = erro_quadro_q;
    assign db_estado     = estado_q;
    assign db_dado       = dado;

endmodule

// File: tb/tb_sonar_receptor_serial.sv
// Directed bench for sonar_receptor_serial: frames, errors, glitch and reset.
module tb_sonar_receptor_serial;

    localparam int unsigned D = 16;
    // start drive -> 2 sync flops + edge detect, D/2 to confirm, 10 bit periods, +1 parser
    localparam int unsigned LAT = 10 * D + D / 2 + 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_serial;
    logic [11:0] angulo;
    logic [15:0] distancia;
    logic        pronto;
    logic        erro_paridade;
    logic        erro_quadro;
    logic [3:0]  db_estado;
    logic [3:0]  db_estado_rx;
    logic [6:0]  db_dado;

    sonar_receptor_serial #(
        .DIVISOR     (D),
        .SYNC_STAGES (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .angulo         (angulo),
        .distancia      (distancia),
        .pronto         (pronto),
        .erro_paridade  (erro_paridade),
        .erro_quadro    (erro_quadro),
        .db_estado      (db_estado),
        .db_estado_rx   (db_estado_rx),
        .db_dado        (db_dado)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned pronto_cnt = 0, epar_cnt = 0, equa_cnt = 0, both_cnt = 0;
    int unsigned overlap_cnt = 0, long_cnt = 0, bv_cnt = 0;
    int unsigned pronto_cyc = 0, last_start_cyc = 0;
    logic        pronto_ant = 1'b0;

    always @(negedge clock) begin
        if (pronto) begin
            pronto_cnt++;
            pronto_cyc = cyc;
            if (pronto_ant) long_cnt++;
            if (erro_paridade || erro_quadro) overlap_cnt++;
        end
        if (erro_paridade) epar_cnt++;
        if (erro_quadro) equa_cnt++;
        if (erro_paridade && erro_quadro) both_cnt++;
        if (dut.byte_valido) bv_cnt++;
        pronto_ant = pronto;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [6:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        last_start_cyc = cyc + 1;
        entrada_serial = 1'b0;
        repeat (D) @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            entrada_serial = b[i];
            repeat (D) @(negedge clock);
        end
        entrada_serial = par;
        repeat (D) @(negedge clock);
        entrada_serial = ~bad_stop;
        repeat (D) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (D) @(negedge clock);
    endtask

    task automatic send_str(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            send_byte(c[6:0], 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0;
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_angulo", 32'(angulo), 32'h000);
        chk("rst_distancia", 32'(distancia), 32'h0000);
        chk("rst_pronto", 32'(pronto), 32'h0);
        chk("rst_erro_paridade", 32'(erro_paridade), 32'h0);
        chk("rst_erro_quadro", 32'(erro_quadro), 32'h0);
        chk("rst_db_estado", 32'(db_estado), 32'h0);
        chk("rst_db_estado_rx", 32'(db_estado_rx), 32'h0);
        chk("rst_db_dado", 32'(db_dado), 32'h00);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("rx_idle_state", 32'(db_estado_rx), 32'h1);

        // low glitch of D/4 clocks on idle line
        entrada_serial = 1'b0;
        repeat (D / 4) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (2 * D) @(negedge clock);
        chk("glitch_no_byte", bv_cnt, 0);
        chk("glitch_no_errors", epar_cnt + equa_cnt, 0);
        chk("glitch_rx_state", 32'(db_estado_rx), 32'h1);

        send_str("045,0123#");
        chk("f1_angulo", 32'(angulo), 32'h045);
        chk("f1_distancia", 32'(distancia), 32'h0123);
        chk("f1_pronto_count", pronto_cnt, 1);
        chk("f1_latency", pronto_cyc - last_start_cyc, LAT);
        chk("f1_no_errors", epar_cnt + equa_cnt, 0);
        chk("f1_bytes", bv_cnt, 9);
        chk("f1_db_dado", 32'(db_dado), 32'h23);

        send_str("180,0500#");
        send_str("090,0042#");
        chk("b2b_pronto_count", pronto_cnt, 3);
        chk("b2b_angulo", 32'(angulo), 32'h090);
        chk("b2b_distancia", 32'(distancia), 32'h0042);

        // 'X' in ANG2 and later '3' in VIRGULA each raise erro_quadro
        send_str("04X,0123#");
        chk("bad_frame_quadro", equa_cnt, 2);
        chk("bad_frame_no_pronto", pronto_cnt, 3);
        chk("bad_frame_angulo_hold", 32'(angulo), 32'h090);
        chk("bad_frame_dist_hold", 32'(distancia), 32'h0042);
        send_str("030,0010#");
        chk("recover_angulo", 32'(angulo), 32'h030);
        chk("recover_distancia", 32'(distancia), 32'h0010);
        chk("recover_pronto", pronto_cnt, 4);

        send_str("12");
        send_byte(7'h35, 1'b1, 1'b0);
        chk("par_err_count", epar_cnt, 1);
        chk("par_err_no_quadro", equa_cnt, 2);
        chk("par_err_state", 32'(db_estado), 32'h0);
        chk("par_err_angulo_hold", 32'(angulo), 32'h030);
        send_str("123,4567#");
        chk("par_next_angulo", 32'(angulo), 32'h123);
        chk("par_next_distancia", 32'(distancia), 32'h4567);
        chk("par_next_pronto", pronto_cnt, 5);

        send_byte(7'h37, 1'b1, 1'b1);
        chk("both_same_cycle", both_cnt, 1);
        chk("both_paridade", epar_cnt, 2);
        chk("both_quadro", equa_cnt, 3);

        send_str("555,1");
        chk("mid_state_dist1", 32'(db_estado), 32'h5);
        entrada_serial = 1'b0;
        repeat (D + 3) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_angulo", 32'(angulo), 32'h000);
        chk("midrst_distancia", 32'(distancia), 32'h0000);
        chk("midrst_db_estado", 32'(db_estado), 32'h0);
        chk("midrst_db_estado_rx", 32'(db_estado_rx), 32'h0);
        reset = 1'b1;
        repeat (12 * D) @(negedge clock);
        send_str("007,0999#");
        chk("post_rst_angulo", 32'(angulo), 32'h007);
        chk("post_rst_distancia", 32'(distancia), 32'h0999);
        chk("post_rst_pronto", pronto_cnt, 6);
        chk("pronto_single_cycle", long_cnt, 0);
        chk("pronto_no_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sonar_receptor_serial.md
Name: sonar_receptor_serial

Overview:
- Receiving end of the sonar's serial link.
- Deserialises the UART stream produced on saida_serial and parses the ASCII frame "aaa,dddd#": 3-digit angle, comma, 4-digit distance, terminator.
- Presents angle and distance as BCD with a one-cycle pronto strobe.
- Sits on the monitoring board / second FPGA, driving 7-segment displays and downstream logic.

Parameters:
- DIVISOR, 434, clocks per bit (50 MHz / 115200 baud); minimum 8.
- SYNC_STAGES, 2, flip-flops in the rx synchroniser; minimum 2.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; reset=0 sampled on a rising edge clears everything.
- entrada_serial  in  1  UART line, idle high; 7 data bits LSB first, odd parity, 2 stop bits.
- angulo  out  12  BCD angle {hundreds,tens,units}; reset 12'h000.
- distancia  out  16  BCD distance {thousands..units}; reset 16'h0000.
- pronto  out  1  one-cycle pulse when a complete valid frame has been accepted; reset 0.
- erro_paridade  out  1  one-cycle pulse on a parity error; reset 0.
- erro_quadro  out  1  one-cycle pulse on a stop-bit or frame-syntax error; reset 0.
- db_estado  out  4  parser state code; reset 4'h0.
- db_estado_rx  out  4  UART receiver state code; reset 4'h0.
- db_dado  out  7  last received byte; reset 7'h00.

Behaviour:
- Synchroniser
  - entrada_serial passes through SYNC_STAGES flip-flops, reset to 1.
  - All receive logic uses the synchronised signal.
- UART receiver states: INICIAL, ESPERA_INICIO, CONFIRMA_INICIO, DADOS, PARIDADE, PARADA1, PARADA2.
  - Falling edge in ESPERA_INICIO starts the tick counter.
  - At DIVISOR/2 the line is re-sampled. If high, it is treated as a glitch: return to ESPERA_INICIO, no byte, no error.
  - After start confirmation, each subsequent bit is sampled every DIVISOR clocks, at bit centre.
  - PARADA1 sample must be 1. PARADA2 is only timed, not checked.
  - At the PARADA2 centre sample, byte_valido pulses for 1 cycle. It carries flags par_ok (ones count of data+parity is odd) and stop_ok.
  - After that sample the receiver is immediately ready for the next start bit.
- Parser states: ESPERA, ANG1, ANG2, VIRGULA, DIST0, DIST1, DIST2, DIST3, FIM.
  - Digit means ASCII 0x30..0x39. The stored nibble is byte[3:0].
  - ESPERA: digit → shadow ang[11:8], go to ANG1. Any other byte is ignored silently.
  - ANG1 and ANG2: digit → next nibble, advance.
  - VIRGULA: 0x2C → DIST0.
  - DIST0..DIST3: digit → shadow dist nibble, advance. DIST3 goes to FIM.
  - FIM: 0x23 → commit shadow registers to angulo/distancia and pulse pronto; both happen in the same cycle, 1 clock after byte_valido; go to ESPERA.
  - Unexpected byte in any state other than ESPERA → erro_quadro pulse, go to ESPERA; outputs hold. Exception: 0x23 received mid-frame also goes to ESPERA with erro_quadro.
  - byte_valido with par_ok=0 → erro_paridade pulse, frame discarded, ESPERA.
  - byte_valido with stop_ok=0 → erro_quadro pulse, frame discarded, ESPERA.
  - If both parity and stop fail, both error pulses assert in the same cycle.
  - angulo/distancia change only on a valid commit, never partially.
- Timing
  - Back-to-back frames with zero idle between bytes are supported.
  - Pulses never overlap pronto.
- Reset mid-byte or mid-frame: all state returns to idle/ESPERA; outputs take their reset values on the next edge; partial data is lost.
- Range: no check on angle ≤ 180 or distance value; any digits are accepted.

Decomposition:
- Package sonar_serial_pkg holds:
  - ASCII constants: ASCII_ZERO=7'h30, ASCII_NOVE=7'h39, ASCII_VIRGULA=7'h2C, ASCII_HASH=7'h23.
  - Parser state encodings.
  - Receiver state encodings.
  - Default DIVISOR.
- Sub-module rx_serial_7o2: synchroniser, tick counter, receive FSM, shift register. Outputs byte_valido, dado[6:0], par_ok, stop_ok.
- Parser FSM and shadow registers live in the top module.

Test Plan:
- Bytes "045,0123#" sent at DIVISOR=434 → angulo=12'h045, distancia=16'h0123, pronto high exactly 1 cycle, 1 clock after the centre of the last PARADA2; no error pulses.
- Two back-to-back frames "180,0500#" then "090,0042#" with no idle → two pronto pulses; final angulo=12'h090, distancia=16'h0042.
- "04X,0123#" → erro_quadro pulse at 'X'; the remaining bytes, up to and including the terminator, produce no pronto. Then "030,0010#" → angulo=12'h030.
- Byte '5' sent with wrong parity bit inside a frame → erro_paridade pulse; outputs keep previous values; the next valid frame commits normally.
- Low pulse of DIVISOR/4 clocks on idle line → no byte_valido, no errors, db_estado_rx back to ESPERA_INICIO.
- reset=0 for 1 cycle during DIST1 of a frame, then "007,0999#" → after reset outputs read 0; the subsequent frame gives angulo=12'h007, distancia=16'h0999.
